// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter, one command byte per frame.
// Define PS2_TX_TIMEOUT_EN to add the per-frame watchdog abort.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK, WAITIDLE} state_t;

    state_t           state, state_n;
    logic [1:0]       clk_sync, data_sync;
    logic             clk_prev;
    logic             sync_clk, sync_data, fall;
    logic [9:0]       shreg, shreg_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [INH_W-1:0] inh_cnt, inh_cnt_n;
    logic             clk_oe_n, data_oe_n, busy_n, done_n, ack_err_n;

    assign sync_clk  = clk_sync[1];
    assign sync_data = data_sync[1];
    assign fall      = clk_prev & ~sync_clk;
    assign tx_ready  = (state == IDLE);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt, wd_n;
    logic            timeout_n;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        inh_cnt_n = inh_cnt;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        busy_n    = busy;
        done_n    = 1'b0;
        ack_err_n = ack_err;
`ifdef PS2_TX_TIMEOUT_EN
        wd_n      = wd_cnt;
        timeout_n = timeout_err;
`endif
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    shreg_n   = {1'b1, ~^tx_data, tx_data};
                    ack_err_n = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
                    timeout_n = 1'b0;
`endif
                    busy_n    = 1'b1;
                    inh_cnt_n = '0;
                    clk_oe_n  = 1'b1;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                // Start bit goes low one cycle before the clock is released.
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    state_n   = RTS;
`ifdef PS2_TX_TIMEOUT_EN
                    wd_n      = '0;
`endif
                end else begin
                    inh_cnt_n = inh_cnt + INH_W'(1);
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 2))
                        data_oe_n = 1'b1;
                end
            end
            RTS: begin
                if (fall) begin
                    bit_cnt_n = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    data_oe_n = ~shreg[0];
                    shreg_n   = {1'b1, shreg[9:1]};
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9)
                        state_n = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    ack_err_n = sync_data;
                    state_n   = WAITIDLE;
                end
            end
            WAITIDLE: begin
                if (sync_clk && sync_data) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (state != IDLE && state != INHIBIT) begin
            wd_n = wd_cnt + WD_W'(1);
            if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                timeout_n = 1'b1;
                done_n    = 1'b1;
                busy_n    = 1'b0;
                state_n   = IDLE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            clk_sync    <= '1;
            data_sync   <= '1;
            clk_prev    <= 1'b1;
            shreg       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
        end else begin
            state       <= state_n;
            clk_sync    <= {clk_sync[0], ps2_clk_in};
            data_sync   <= {data_sync[0], ps2_data_in};
            clk_prev    <= sync_clk;
            shreg       <= shreg_n;
            bit_cnt     <= bit_cnt_n;
            inh_cnt     <= inh_cnt_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            busy        <= busy_n;
            done        <= done_n;
            ack_err     <= ack_err_n;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            wd_cnt      <= wd_n;
            timeout_err <= timeout_n;
        end
    end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain line model plus a PS/2 device
// model that clocks each frame and compares it against the byte's expected frame.
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TMO  = 200;
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, busy, done, ack_err, timeout_err;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk, dev_data;

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .ack_err(ack_err),
        .timeout_err(timeout_err), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line monitor: clock-low run length and inhibit/done ordering.
    int   run = 0, last_run = 0, inh_starts = 0, done_cnt = 0, order_err = 0;
    logic prev_oe = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            run = 0; inh_starts = 0; done_cnt = 0; prev_oe = 1'b0;
        end else begin
            if (ps2_clk_oe && !prev_oe) begin
                if (inh_starts != done_cnt) order_err++;
                inh_starts++;
            end
            if (ps2_clk_oe) run++;
            else if (run != 0) begin
                last_run = run;
                run = 0;
            end
            if (done) done_cnt++;
            prev_oe = ps2_clk_oe;
        end
    end

    function automatic logic odd_parity(input logic [7:0] b);
        int ones = 0;
        for (int k = 0; k < 8; k++) ones += int'((b >> k) & 8'd1);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept busy", busy, 1'b1);
        check("accept ready", tx_ready, 1'b0);
        check("accept ack_err clear", ack_err, 1'b0);
        check("accept timeout_err clear", timeout_err, 1'b0);
    endtask

    task automatic wait_rts(output bit found);
        found = 0;
        for (int i = 0; i < INH + 100; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) begin
                found = 1;
                break;
            end
        end
    endtask

    task automatic dev_pulse(output logic sampled);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        sampled = ps2_data_in;
        dev_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic device_frame(input logic [7:0] b, input logic exp_par, input logic ack_bit,
                                input logic exp_ack_err, input string tag, input bit check_idle);
        logic [10:0] bits;
        bit          found, got_done;
        logic        ack_at_done;
        wait_rts(found);
        check({tag, " rts reached"}, found, 1'b1);
        if (!found) return;
        check({tag, " busy in frame"}, busy, 1'b1);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 11; i++) dev_pulse(bits[i]);
        dev_data = ack_bit;
        repeat (2) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        got_done    = 0;
        ack_at_done = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got_done    = 1;
                ack_at_done = ack_err;
                break;
            end
        end
        check({tag, " inhibit length"}, last_run, INH);
        check({tag, " start bit"}, bits[0], 1'b0);
        check({tag, " data bits"}, bits[8:1], b);
        check({tag, " parity bit"}, bits[9], exp_par);
        check({tag, " stop bit"}, bits[10], 1'b1);
        check({tag, " done pulse"}, got_done, 1'b1);
        check({tag, " ack_err at done"}, ack_at_done, exp_ack_err);
        if (check_idle) begin
            @(negedge clk);
            check({tag, " done one cycle"}, done, 1'b0);
            check({tag, " idle ready"}, tx_ready, 1'b1);
            check({tag, " idle busy"}, busy, 1'b0);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ack_bit;
        logic       exp_par;
        logic       exp_ack_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #900000;
        $display("FAIL global time limit: got running, expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] rb;
        logic       rack, s;
        bit         found;
        int         base, cyc;

        vecs[0] = '{8'hED, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h01, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b1};

        reset = 1'b0; tx_valid = 1'b0; tx_data = '0; dev_clk = 1'b1; dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tx_ready", tx_ready, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset ack_err", ack_err, 1'b0);
        check("reset timeout_err", timeout_err, 1'b0);
        check("reset clk_oe", ps2_clk_oe, 1'b0);
        check("reset data_oe", ps2_data_oe, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data);
            device_frame(vecs[i].data, vecs[i].exp_par, vecs[i].ack_bit,
                         vecs[i].exp_ack_err, $sformatf("vec%0d", i), 1);
        end
        repeat (30) @(negedge clk);
        check("nack ack_err held", ack_err, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) == 0);
            send(rb);
            device_frame(rb, odd_parity(rb), rack, rack, $sformatf("rnd%0d", i), 1);
        end

        // Back-to-back requests with tx_valid held high.
        base = inh_starts;
        fork
            begin
                int   acc;
                logic prev_ready;
                acc = 0;
                @(negedge clk);
                tx_data  = 8'hF4;
                tx_valid = 1'b1;
                prev_ready = tx_ready;
                for (int c = 0; c < 4000 && acc < 2; c++) begin
                    @(negedge clk);
                    if (prev_ready && !tx_ready) begin
                        acc++;
                        if (acc == 1) tx_data = 8'hAA;
                        else tx_valid = 1'b0;
                    end
                    prev_ready = tx_ready;
                end
                tx_valid = 1'b0;
            end
            begin
                device_frame(8'hF4, 1'b0, 1'b0, 1'b0, "b2b first", 0);
                device_frame(8'hAA, 1'b1, 1'b0, 1'b0, "b2b second", 0);
            end
        join
        repeat (60) @(negedge clk);
        check("b2b frame count", inh_starts - base, 2);
        check("b2b idle after", tx_ready, 1'b1);
        check("inhibit only after done", order_err, 0);

        // Reset during INHIBIT releases the clock line asynchronously.
        send(8'h3C);
        repeat (5) @(negedge clk);
        check("pre-reset clk_oe", ps2_clk_oe, 1'b1);
        @(posedge clk); #2;
        reset = 1'b0; #1;
        check("async reset clk_oe", ps2_clk_oe, 1'b0);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset mid-SHIFT releases the data line asynchronously.
        send(8'h00);
        wait_rts(found);
        check("shift reset rts reached", found, 1'b1);
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 3; i++) dev_pulse(s);
        check("pre-reset data_oe", ps2_data_oe, 1'b1);
        @(posedge clk); #2;
        reset = 1'b0; #1;
        check("shift reset clk_oe", ps2_clk_oe, 1'b0);
        check("shift reset data_oe", ps2_data_oe, 1'b0);
        check("shift reset busy", busy, 1'b0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("post-reset tx_ready", tx_ready, 1'b1);

        // Missing device: no clocks after the request to send.
        send(8'h55);
`ifdef PS2_TX_TIMEOUT_EN
        found = 0;
        for (int i = 0; i < INH + 10; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe) begin found = 1; break; end
        end
        check("timeout rts reached", found, 1'b1);
        for (cyc = 1; cyc <= TMO + 20; cyc++) begin
            @(negedge clk);
            if (done) break;
        end
        check("timeout latency", cyc, TMO);
        check("timeout_err set", timeout_err, 1'b1);
        check("timeout clk_oe", ps2_clk_oe, 1'b0);
        check("timeout data_oe", ps2_data_oe, 1'b0);
        check("timeout busy", busy, 1'b0);
        repeat (10) @(negedge clk);
        check("timeout_err held", timeout_err, 1'b1);
        send(8'hED);
        device_frame(8'hED, 1'b1, 1'b0, 1'b0, "after timeout", 1);
`else
        repeat (3 * TMO) @(negedge clk);
        check("no watchdog busy held", busy, 1'b1);
        check("no watchdog not ready", tx_ready, 1'b0);
        check("no watchdog timeout_err", timeout_err, 1'b0);
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("recovered tx_ready", tx_ready, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
